// File: rtl/sd_block_reader_if.sv
// Read-side handshake between the SD block reader and the photo-loader stage.
// The loader issues single-cycle requests and consumes the 16-bit payload stream.
interface sd_block_reader_if;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        rd_val_en;
  logic [15:0] rd_val_data;
  logic        rd_err;

  modport master (
    output rd_start_en,
    output rd_sec_addr,
    input  rd_busy,
    input  rd_val_en,
    input  rd_val_data,
    input  rd_err
  );

  modport slave (
    input  rd_start_en,
    input  rd_sec_addr,
    output rd_busy,
    output rd_val_en,
    output rd_val_data,
    output rd_err
  );
endinterface

// File: rtl/sd_block_reader.sv
// SPI-mode SD single-block reader: sends CMD17 for one 512-byte sector and
// streams the payload as 16-bit words, then closes with CS-high tail clocks.
module sd_block_reader #(
  parameter int SCLK_HALF     = 2,
  parameter int RESP_TIMEOUT  = 64,
  parameter int TOKEN_TIMEOUT = 100000,
  parameter int TAIL_CLKS     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sd_init_done,
  input  logic                sd_miso,
  output logic                sd_cs,
  output logic                sd_sclk,
  output logic                sd_mosi,
  sd_block_reader_if.slave    rd
);

  localparam int DIV_W   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int MAX_A   = (TOKEN_TIMEOUT > 4096) ? TOKEN_TIMEOUT : 4096;
  localparam int MAX_B   = (RESP_TIMEOUT > TAIL_CLKS) ? RESP_TIMEOUT : TAIL_CLKS;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [7:0] CMD17     = 8'h51;
  localparam logic [7:0] CMD17_CRC = 8'hFF;
  localparam logic [7:0] TOKEN_SB  = 8'hFE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    RESP  = 3'd2,
    TOKEN = 3'd3,
    DATA  = 3'd4,
    CRC   = 3'd5,
    TAIL  = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t             state_r;
  logic [DIV_W-1:0]   div_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               r1_run_r;
  logic [14:0]        rx_r;
  logic [46:0]        cmd_r;

  logic               tick_s;
  logic               rise_s;
  logic               fall_s;
  logic [7:0]         byte_s;
  logic [15:0]        word_s;

  // SCLK edge strobes and the byte/word views that include the bit being sampled
  assign tick_s = (div_r == DIV_W'(SCLK_HALF - 1));
  assign rise_s = (state_r != IDLE) && tick_s && !sd_sclk;
  assign fall_s = (state_r != IDLE) && tick_s && sd_sclk;
  assign byte_s = {rx_r[6:0], sd_miso};
  assign word_s = {rx_r, sd_miso};

  // SCLK divider, MOSI shifter, MISO sampler and the read state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      div_r          <= '0;
      cnt_r          <= '0;
      r1_run_r       <= 1'b0;
      rx_r           <= '0;
      cmd_r          <= '1;
      sd_cs          <= 1'b1;
      sd_sclk        <= 1'b0;
      sd_mosi        <= 1'b1;
      rd.rd_busy     <= 1'b0;
      rd.rd_val_en   <= 1'b0;
      rd.rd_val_data <= 16'h0000;
      rd.rd_err      <= 1'b0;
    end else begin
      rd.rd_val_en <= 1'b0;
      rd.rd_err    <= 1'b0;

      if (state_r == IDLE) begin
        div_r <= '0;
      end else if (tick_s) begin
        div_r   <= '0;
        sd_sclk <= ~sd_sclk;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end

      // Ones shift in behind the command, so MOSI idles high once it is sent
      if (fall_s) begin
        sd_mosi <= cmd_r[46];
        cmd_r   <= {cmd_r[45:0], 1'b1};
      end

      if (rise_s) begin
        rx_r <= {rx_r[13:0], sd_miso};
      end

      case (state_r)
        IDLE: begin
          if (rd.rd_start_en && sd_init_done) begin
            cmd_r      <= {CMD17[6:0], rd.rd_sec_addr, CMD17_CRC};
            sd_mosi    <= CMD17[7];
            sd_cs      <= 1'b0;
            rd.rd_busy <= 1'b1;
            cnt_r      <= '0;
            r1_run_r   <= 1'b0;
            state_r    <= CMD;
          end
        end

        CMD: begin
          if (rise_s) begin
            if (cnt_r == CNT_W'(47)) begin
              cnt_r   <= '0;
              state_r <= RESP;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        // The first low bit is R1's MSB, so it is counted as bit one of eight
        RESP: begin
          if (rise_s) begin
            if (!r1_run_r) begin
              if (!sd_miso) begin
                r1_run_r <= 1'b1;
                cnt_r    <= CNT_W'(1);
              end else if (cnt_r == CNT_W'(RESP_TIMEOUT - 1)) begin
                state_r <= ERR;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end else if (cnt_r == CNT_W'(7)) begin
              cnt_r   <= '0;
              state_r <= (byte_s == 8'h00) ? TOKEN : ERR;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        TOKEN: begin
          if (rise_s) begin
            if (byte_s == TOKEN_SB) begin
              cnt_r   <= '0;
              state_r <= DATA;
            end else if (cnt_r == CNT_W'(TOKEN_TIMEOUT - 1)) begin
              state_r <= ERR;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        DATA: begin
          if (rise_s) begin
            if (cnt_r[3:0] == 4'hF) begin
              rd.rd_val_data <= word_s;
              rd.rd_val_en   <= 1'b1;
            end
            if (cnt_r == CNT_W'(4095)) begin
              cnt_r   <= '0;
              state_r <= CRC;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        CRC: begin
          if (rise_s) begin
            if (cnt_r == CNT_W'(15)) begin
              cnt_r   <= '0;
              state_r <= TAIL;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        // CS rises on a falling edge so every counted tail clock sees CS high
        TAIL: begin
          if (rise_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else if (fall_s) begin
            sd_cs <= 1'b1;
            if (cnt_r == CNT_W'(TAIL_CLKS)) begin
              rd.rd_busy <= 1'b0;
              state_r    <= IDLE;
            end
          end
        end

        ERR: begin
          rd.rd_err <= 1'b1;
          sd_cs     <= 1'b1;
          cnt_r     <= '0;
          state_r   <= TAIL;
        end

        default: begin
          sd_cs      <= 1'b1;
          rd.rd_busy <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader with a behavioural SPI-mode SD card model.
module tb_sd_block_reader;

  localparam int SCLK_HALF     = 2;
  localparam int RESP_TIMEOUT  = 64;
  localparam int TOKEN_TIMEOUT = 200;
  localparam int TAIL_CLKS     = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sd_init_done;
  logic sd_miso = 1'b1;
  logic sd_cs;
  logic sd_sclk;
  logic sd_mosi;

  sd_block_reader_if rd_if ();

  sd_block_reader #(
    .SCLK_HALF     (SCLK_HALF),
    .RESP_TIMEOUT  (RESP_TIMEOUT),
    .TOKEN_TIMEOUT (TOKEN_TIMEOUT),
    .TAIL_CLKS     (TAIL_CLKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sd_init_done (sd_init_done),
    .sd_miso      (sd_miso),
    .sd_cs        (sd_cs),
    .sd_sclk      (sd_sclk),
    .sd_mosi      (sd_mosi),
    .rd           (rd_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- card model ----------------
  logic [7:0] cfg_r1       = 8'h00;
  logic       cfg_stuck    = 1'b0;
  logic       cfg_no_token = 1'b0;

  function automatic logic [7:0] resp_byte(input int b);
    if (cfg_stuck)                          return 8'hFF;
    if (b < 2)                              return 8'hFF;
    if (b == 2)                             return cfg_r1;
    if (cfg_r1 != 8'h00 || cfg_no_token)    return 8'hFF;
    if (b < 13)                             return 8'hFF;
    if (b == 13)                            return 8'hFE;
    if (b < 526)                            return 8'(b - 14);
    if (b == 526)                           return 8'hA5;
    if (b == 527)                           return 8'h5A;
    return 8'hFF;
  endfunction

  function automatic logic resp_bit(input int i);
    logic [7:0] b;
    b = resp_byte(i / 8);
    return b[3'(7 - (i % 8))];
  endfunction

  int          nbits     = 0;
  int          midx      = 0;
  int          mosi_zero = 0;
  logic [47:0] cmd_seen  = '0;

  always @(posedge sd_sclk or posedge sd_cs) begin
    if (sd_cs) begin
      nbits <= 0;
    end else begin
      if (nbits < 48) cmd_seen <= {cmd_seen[46:0], sd_mosi};
      else if (!sd_mosi) mosi_zero <= mosi_zero + 1;
      nbits <= nbits + 1;
    end
  end

  always @(negedge sd_sclk or posedge sd_cs) begin
    if (sd_cs) begin
      sd_miso <= 1'b1;
      midx    <= 0;
    end else if (nbits >= 48) begin
      sd_miso <= resp_bit(midx);
      midx    <= midx + 1;
    end else begin
      sd_miso <= 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] words [256];
  logic prev_busy  = 1'b0;
  logic prev_sclk  = 1'b0;
  logic cs_at_fall = 1'b0;
  int strobes = 0, err_cnt = 0, busy_falls = 0, rises = 0, tail_rises = 0;
  int busy_cycles = 0, err_at = -1, viol = 0;

  always @(negedge clk) begin
    prev_busy <= rd_if.rd_busy;
    prev_sclk <= sd_sclk;
    if (rd_if.rd_busy && !prev_busy) begin
      strobes     <= 0;
      err_cnt     <= 0;
      rises       <= 0;
      tail_rises  <= 0;
      busy_cycles <= 1;
      err_at      <= -1;
    end else begin
      if (rd_if.rd_busy) busy_cycles <= busy_cycles + 1;
      if (rd_if.rd_busy && sd_sclk && !prev_sclk) begin
        rises <= rises + 1;
        if (sd_cs) tail_rises <= tail_rises + 1;
      end
      if (rd_if.rd_val_en) begin
        words[strobes[7:0]] <= rd_if.rd_val_data;
        strobes <= strobes + 1;
      end
      if (rd_if.rd_err) begin
        err_cnt <= err_cnt + 1;
        err_at  <= rises;
      end
    end
    if ((rd_if.rd_val_en && rd_if.rd_err) || (rd_if.rd_err && !rd_if.rd_busy)) viol <= viol + 1;
    if (!rd_if.rd_busy && prev_busy) begin
      busy_falls <= busy_falls + 1;
      cs_at_fall <= sd_cs;
    end
  end

  function automatic int count_bad();
    int n = 0;
    for (int k = 0; k < 256; k++) begin
      if (words[k] !== {8'(2 * k), 8'(2 * k + 1)}) n++;
    end
    return n;
  endfunction

  task automatic start_read(input logic [31:0] addr);
    @(negedge clk);
    rd_if.rd_start_en = 1'b1;
    rd_if.rd_sec_addr = addr;
    @(negedge clk);
    rd_if.rd_start_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (rd_if.rd_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_bit({tag, "_done"}, rd_if.rd_busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int f0;
    int n;
    rst_n             = 1'b0;
    sd_init_done      = 1'b1;
    rd_if.rd_start_en = 1'b0;
    rd_if.rd_sec_addr = 32'h0000_0000;
    repeat (3) @(negedge clk);
    check_bit("rst_cs",    sd_cs,             1'b1);
    check_bit("rst_sclk",  sd_sclk,           1'b0);
    check_bit("rst_mosi",  sd_mosi,           1'b1);
    check_bit("rst_busy",  rd_if.rd_busy,     1'b0);
    check_bit("rst_val",   rd_if.rd_val_en,   1'b0);
    check_bit("rst_err",   rd_if.rd_err,      1'b0);
    check_int("rst_data",  int'(rd_if.rd_val_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // good block at sector 8448
    f0 = busy_falls;
    start_read(32'd8448);
    check_bit("t1_busy_rise", rd_if.rd_busy, 1'b1);
    check_bit("t1_cs_low",    sd_cs,         1'b0);
    wait_idle("t1", 20000);
    check_vec("t1_cmd",       cmd_seen, 48'h51_0000_2100_FF);
    check_int("t1_strobes",   strobes, 256);
    check_int("t1_word0",     int'(words[0]), 32'h0001);
    check_int("t1_word255",   int'(words[255]), 32'hFEFF);
    check_int("t1_bad_words", count_bad(), 0);
    check_int("t1_err",       err_cnt, 0);
    check_int("t1_falls",     busy_falls - f0, 1);
    check_int("t1_tail",      tail_rises, 8);
    check_bit("t1_cs_fall",   cs_at_fall, 1'b1);
    check_int("t1_sclk_rises", rises, 4280);
    check_bit("t1_busy_len",  (busy_cycles >= 17118 && busy_cycles <= 17122), 1'b1);

    // R1 = 0x04
    cfg_r1 = 8'h04;
    f0 = busy_falls;
    start_read(32'd99);
    wait_idle("t2", 2000);
    check_int("t2_err",     err_cnt, 1);
    check_int("t2_err_at",  err_at, 72);
    check_int("t2_strobes", strobes, 0);
    check_int("t2_tail",    tail_rises, 8);
    check_int("t2_falls",   busy_falls - f0, 1);

    // follow-up read, with a start pulse landing mid-DATA
    cfg_r1 = 8'h00;
    f0 = busy_falls;
    start_read(32'd11264);
    n = 0;
    while (strobes < 50 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_bit("t5_in_data", (strobes >= 50), 1'b1);
    start_read(32'hFFFF_FFFF);
    wait_idle("t2b", 20000);
    check_vec("t2b_cmd",     cmd_seen, 48'h51_0000_2C00_FF);
    check_int("t2b_strobes", strobes, 256);
    check_int("t2b_bad",     count_bad(), 0);
    check_int("t2b_err",     err_cnt, 0);
    check_int("t5_falls",    busy_falls - f0, 1);

    // MISO stuck high: R1 timeout
    cfg_stuck = 1'b1;
    f0 = busy_falls;
    start_read(32'hFFFF_FFFF);
    wait_idle("t3", 2000);
    check_vec("t3_cmd",     cmd_seen, 48'h51_FFFF_FFFF_FF);
    check_int("t3_err",     err_cnt, 1);
    check_int("t3_err_at",  err_at, 112);
    check_int("t3_strobes", strobes, 0);
    check_int("t3_falls",   busy_falls - f0, 1);

    // token never arrives
    cfg_stuck    = 1'b0;
    cfg_no_token = 1'b1;
    f0 = busy_falls;
    start_read(32'h0000_0000);
    wait_idle("t4", 3000);
    check_vec("t4_cmd",     cmd_seen, 48'h51_0000_0000_FF);
    check_int("t4_err",     err_cnt, 1);
    check_int("t4_err_at",  err_at, 272);
    check_int("t4_strobes", strobes, 0);
    check_int("t4_tail",    tail_rises, 8);
    check_int("t4_falls",   busy_falls - f0, 1);

    // start while sd_init_done=0
    cfg_no_token = 1'b0;
    sd_init_done = 1'b0;
    f0 = busy_falls;
    start_read(32'd1234);
    repeat (20) @(negedge clk);
    check_bit("t5_nobusy", rd_if.rd_busy, 1'b0);
    check_bit("t5_cs",     sd_cs,         1'b1);
    check_int("t5_nofall", busy_falls - f0, 0);
    sd_init_done = 1'b1;

    // reset at word 100, then a clean read
    start_read(32'd5);
    n = 0;
    while (strobes < 100 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_int("t6_at100", strobes, 100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_bit("t6_cs",   sd_cs,           1'b1);
    check_bit("t6_sclk", sd_sclk,         1'b0);
    check_bit("t6_busy", rd_if.rd_busy,   1'b0);
    check_bit("t6_val",  rd_if.rd_val_en, 1'b0);
    repeat (5) @(negedge clk);
    check_int("t6_frozen", strobes, 100);
    rst_n = 1'b1;
    @(negedge clk);
    start_read(32'd7);
    wait_idle("t6b", 20000);
    check_vec("t6b_cmd",     cmd_seen, 48'h51_0000_0007_FF);
    check_int("t6b_strobes", strobes, 256);
    check_int("t6b_bad",     count_bad(), 0);
    check_int("t6b_err",     err_cnt, 0);

    check_int("glob_viol",      viol, 0);
    check_int("glob_mosi_zero", mosi_zero, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
